// File: rtl/morse_pkg.sv
// Shared Morse definitions: field widths, letter code record, A..Z table and
// the transmitter state encoding.
package morse_pkg;

    localparam int NUM_LETTERS = 26;
    localparam int LEN_W       = 3;
    localparam int CODE_W      = 4;

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [CODE_W-1:0] code;
    } morse_code_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MARK,
        ST_SPACE,
        ST_CHAR_GAP
    } tx_state_e;

    // code[len-1] is sent first; a 1 bit is a dash, a 0 bit is a dot
    function automatic morse_code_t morse_lookup(input logic [4:0] letter);
        morse_code_t c;
        case (letter)
            5'd0:    c = '{3'd2, 4'b0001}; // A .-
            5'd1:    c = '{3'd4, 4'b1000}; // B -...
            5'd2:    c = '{3'd4, 4'b1010}; // C -.-.
            5'd3:    c = '{3'd3, 4'b0100}; // D -..
            5'd4:    c = '{3'd1, 4'b0000}; // E .
            5'd5:    c = '{3'd4, 4'b0010}; // F ..-.
            5'd6:    c = '{3'd3, 4'b0110}; // G --.
            5'd7:    c = '{3'd4, 4'b0000}; // H ....
            5'd8:    c = '{3'd2, 4'b0000}; // I ..
            5'd9:    c = '{3'd4, 4'b0111}; // J .---
            5'd10:   c = '{3'd3, 4'b0101}; // K -.-
            5'd11:   c = '{3'd4, 4'b0100}; // L .-..
            5'd12:   c = '{3'd2, 4'b0011}; // M --
            5'd13:   c = '{3'd2, 4'b0010}; // N -.
            5'd14:   c = '{3'd3, 4'b0111}; // O ---
            5'd15:   c = '{3'd4, 4'b0110}; // P .--.
            5'd16:   c = '{3'd4, 4'b1101}; // Q --.-
            5'd17:   c = '{3'd3, 4'b0010}; // R .-.
            5'd18:   c = '{3'd3, 4'b0000}; // S ...
            5'd19:   c = '{3'd1, 4'b0001}; // T -
            5'd20:   c = '{3'd3, 4'b0001}; // U ..-
            5'd21:   c = '{3'd4, 4'b0001}; // V ...-
            5'd22:   c = '{3'd3, 4'b0011}; // W .--
            5'd23:   c = '{3'd4, 4'b1001}; // X -..-
            5'd24:   c = '{3'd4, 4'b1011}; // Y -.--
            5'd25:   c = '{3'd4, 4'b1100}; // Z --..
            default: c = '{3'd0, 4'b0000};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/morse_letter_rom.sv
// Combinational letter index to Morse code lookup with range flag.
module morse_letter_rom
    import morse_pkg::*;
(
    input  logic [4:0]  letter_i,
    output morse_code_t code_o,
    output logic        valid_letter_o
);

    assign code_o         = morse_lookup(letter_i);
    assign valid_letter_o = (letter_i < 5'(NUM_LETTERS));

endmodule

// File: rtl/morse_tx_encoder.sv
// Morse transmitter: takes one letter per handshake and keys dots, dashes and
// gaps on key_o with tick-exact durations.
module morse_tx_encoder
    import morse_pkg::*;
#(
    parameter int DOT_TICKS      = 30,
    parameter int DASH_TICKS     = 60,
    parameter int GAP_TICKS      = 10,
    parameter int CHAR_GAP_TICKS = 50,
    parameter int CNT_W          = 6
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       valid_i,
    input  logic [4:0] letter_i,
    output logic       ready_o,
    input  logic       abort_i,
    output logic       key_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    if (DOT_TICKS < 1 || DOT_TICKS >= 2**CNT_W ||
        DASH_TICKS < 1 || DASH_TICKS >= 2**CNT_W ||
        GAP_TICKS < 1 || GAP_TICKS > 2**CNT_W ||
        CHAR_GAP_TICKS < 1 || CHAR_GAP_TICKS > 2**CNT_W) begin : g_bad_timing
        $error("morse_tx_encoder: tick durations out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] DOT_LD  = CNT_W'(DOT_TICKS - 1);
    localparam logic [CNT_W-1:0] DASH_LD = CNT_W'(DASH_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] CG_LD   = CNT_W'(CHAR_GAP_TICKS - 1);

    tx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [CODE_W-1:0] sh_q, sh_d;
    logic              key_q, key_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    morse_code_t       rom_code;
    logic              rom_valid;
    logic [LEN_W-1:0]  shamt;
    logic [CODE_W-1:0] aligned;

    morse_letter_rom u_rom (
        .letter_i       (letter_i),
        .code_o         (rom_code),
        .valid_letter_o (rom_valid)
    );

    // Left-align the code so the current element is always the MSB
    assign shamt   = LEN_W'(CODE_W) - rom_code.len;
    assign aligned = rom_code.code << shamt;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        sh_d    = sh_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (valid_i && rom_valid) begin
                        sh_d    = aligned;
                        rem_d   = rom_code.len;
                        cnt_d   = aligned[CODE_W-1] ? DASH_LD : DOT_LD;
                        state_d = ST_MARK;
                    end else if (valid_i) begin
                        err_d = 1'b1;
                    end
                end
                ST_MARK: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (rem_q > LEN_W'(1)) begin
                        rem_d   = rem_q - 1'b1;
                        sh_d    = sh_q << 1;
                        cnt_d   = GAP_LD;
                        state_d = ST_SPACE;
                    end else begin
                        cnt_d   = CG_LD;
                        state_d = ST_CHAR_GAP;
                    end
                end
                ST_SPACE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        cnt_d   = sh_q[CODE_W-1] ? DASH_LD : DOT_LD;
                        state_d = ST_MARK;
                    end
                end
                ST_CHAR_GAP: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        key_d = (state_d == ST_MARK);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            sh_q    <= '0;
            key_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            sh_q    <= sh_d;
            key_q   <= key_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign key_o   = key_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign busy_o  = (state_q != ST_IDLE);
    assign ready_o = (state_q == ST_IDLE);

endmodule

// File: tb/tb_morse_tx_encoder.sv
// Directed bench for morse_tx_encoder: timing of E/A/Q, error, ignore-while-busy,
// abort, async reset and the full A..Z element patterns.
module tb_morse_tx_encoder;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       valid_i = 1'b0;
    logic [4:0] letter_i = '0;
    logic       abort_i = 1'b0;
    logic       ready_o, key_o, busy_o, done_o, err_o;

    int nerr = 0;
    int nchk = 0;

    morse_tx_encoder dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .valid_i  (valid_i),
        .letter_i (letter_i),
        .ready_o  (ready_o),
        .abort_i  (abort_i),
        .key_o    (key_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .err_o    (err_o)
    );

    always #5 clk_i = ~clk_i;

    string exp_tab [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                            "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                            "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                            "-.--", "--.."};

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_s(input string tag, input string obs, input string exp);
        nchk++;
        assert (obs == exp) else begin
            nerr++;
            $error("FAIL %s observed=%s expected=%s", tag, obs, exp);
        end
    endtask

    // Accept one letter, then decode key_o until done_o: returns the dot/dash
    // pattern, the cycle done_o appeared (acceptance edge ends cycle 0), a flag
    // for any wrong intra-letter gap, and the final gap length.
    task automatic run_letter(input logic [4:0] l, output string pat, output int done_cyc,
                              output int gap_bad, output int last_gap);
        int mark, space, cyc;
        valid_i = 1'b1; letter_i = l;
        step();
        valid_i = 1'b0;
        pat = ""; mark = 0; space = 0; gap_bad = 0; cyc = 1;
        while (cyc < 400 && !done_o) begin
            if (key_o) begin
                if (space > 0) begin
                    if (space != 10) gap_bad = 1;
                    space = 0;
                end
                mark++;
            end else begin
                if (mark > 0) begin
                    pat = {pat, (mark == 30) ? "." : (mark == 60) ? "-" : "?"};
                    mark = 0;
                end
                space++;
            end
            step();
            cyc++;
        end
        done_cyc = cyc;
        last_gap = space;
    endtask

    initial begin
        string pat;
        int dc, gb, lg, ndone, nerr_o, first_done, expc;

        // reset values
        repeat (3) step();
        chk("rst_key", key_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        rst_ni = 1'b1;
        step();

        // E: cycle-exact spot checks
        valid_i = 1'b1; letter_i = 5'd4;
        step();
        valid_i = 1'b0;
        chk("E_key_c1", key_o, 1);
        chk("E_busy_c1", busy_o, 1);
        chk("E_ready_c1", ready_o, 0);
        repeat (29) step();
        chk("E_key_c30", key_o, 1);
        step();
        chk("E_key_c31", key_o, 0);
        repeat (49) step();
        chk("E_done_c80", done_o, 0);
        chk("E_busy_c80", busy_o, 1);
        step();
        chk("E_done_c81", done_o, 1);
        chk("E_ready_c81", ready_o, 1);
        chk("E_key_c81", key_o, 0);
        step();
        chk("E_done_c82", done_o, 0);

        // A and Q full waveforms
        run_letter(5'd0, pat, dc, gb, lg);
        chk_s("A_pattern", pat, ".-");
        chk("A_done_cycle", dc, 151);
        chk("A_gaps", gb, 0);
        chk("A_char_gap", lg, 50);
        step();
        run_letter(5'd16, pat, dc, gb, lg);
        chk_s("Q_pattern", pat, "--.-");
        chk("Q_done_cycle", dc, 291);
        chk("Q_gaps", gb, 0);
        step();

        // out-of-range letter
        valid_i = 1'b1; letter_i = 5'd26;
        step();
        valid_i = 1'b0;
        chk("err_pulse_c1", err_o, 1);
        chk("err_key", key_o, 0);
        chk("err_busy", busy_o, 0);
        chk("err_ready", ready_o, 1);
        step();
        chk("err_pulse_c2", err_o, 0);

        // T with valid held (letter F) while busy: ignored
        valid_i = 1'b1; letter_i = 5'd19;
        step();
        letter_i = 5'd5;
        ndone = 0; nerr_o = 0;
        for (int c = 1; c < 110; c++) begin
            ndone += int'(done_o); nerr_o += int'(err_o);
            step();
        end
        valid_i = 1'b0;
        for (int c = 110; c < 200; c++) begin
            ndone += int'(done_o); nerr_o += int'(err_o);
            step();
        end
        chk("held_valid_done_count", ndone, 1);
        chk("held_valid_err_count", nerr_o, 0);
        chk("held_valid_idle", busy_o, 0);

        // abort during first dash of Q
        valid_i = 1'b1; letter_i = 5'd16;
        step();
        valid_i = 1'b0;
        repeat (19) step();
        chk("abort_key_c20", key_o, 1);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("abort_key_c21", key_o, 0);
        chk("abort_busy_c21", busy_o, 0);
        chk("abort_ready_c21", ready_o, 1);
        chk("abort_done_c21", done_o, 0);
        valid_i = 1'b1; letter_i = 5'd4;
        step();
        valid_i = 1'b0;
        chk("post_abort_key_c22", key_o, 1);
        ndone = 0; first_done = 0;
        for (int c = 22; c < 300; c++) begin
            if (done_o) begin
                ndone++;
                if (first_done == 0) first_done = c;
            end
            step();
        end
        chk("post_abort_done_count", ndone, 1);
        chk("post_abort_done_cycle", first_done, 102);

        // abort in IDLE blocks acceptance and error
        abort_i = 1'b1; valid_i = 1'b1; letter_i = 5'd0;
        step();
        chk("abort_idle_busy", busy_o, 0);
        chk("abort_idle_key", key_o, 0);
        letter_i = 5'd26;
        step();
        abort_i = 1'b0; valid_i = 1'b0;
        chk("abort_idle_err", err_o, 0);
        chk("abort_idle_busy2", busy_o, 0);

        // async reset mid-dash of T
        valid_i = 1'b1; letter_i = 5'd19;
        step();
        valid_i = 1'b0;
        repeat (10) step();
        chk("pre_rst_key", key_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_rst_key", key_o, 0);
        chk("async_rst_busy", busy_o, 0);
        repeat (2) step();
        rst_ni = 1'b1;
        step();
        chk("post_rst_key", key_o, 0);
        chk("post_rst_busy", busy_o, 0);
        chk("post_rst_ready", ready_o, 1);
        chk("post_rst_done", done_o, 0);
        chk("post_rst_err", err_o, 0);

        // all letters: element pattern and total length
        for (int l = 0; l < 26; l++) begin
            string e;
            e = exp_tab[l];
            expc = 51 + 10 * (e.len() - 1);
            for (int k = 0; k < e.len(); k++) expc += (e[k] == "-") ? 60 : 30;
            run_letter(5'(l), pat, dc, gb, lg);
            chk_s($sformatf("pattern_%0d", l), pat, e);
            chk($sformatf("done_cycle_%0d", l), dc, expc);
            chk($sformatf("gaps_%0d", l), gb, 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
